// File: rtl/sync_event_pkg.sv
// -----------------------------------------------------------------------------
// sync_event_pkg
// Shared types and constants for the synchronized-event enqueue block.
//   dbnc_state_e : debounce FSM states (STABLE, CHANGING)
//   event_t      : event layout for the default 32-bit payload
//                  {level, timestamp}; the new level is the MSB
//   ts_width()   : timestamp width for a given payload width
//   fifo_depth() : FIFO entry count for a given log2 depth
// -----------------------------------------------------------------------------
package sync_event_pkg;

  typedef enum logic {
    STABLE   = 1'b0,
    CHANGING = 1'b1
  } dbnc_state_e;

  localparam int unsigned DataWidthDefault = 32;
  localparam int unsigned TsWidthDefault   = DataWidthDefault - 1;
  localparam int unsigned DepthLog2Default = 2;
  localparam int unsigned FifoDepthDefault = 1 << DepthLog2Default;

  // Payload layout at the default width. Other widths keep the same shape:
  // level in the top bit, timestamp in everything below it.
  typedef struct packed {
    logic                      level;
    logic [TsWidthDefault-1:0] ts;
  } event_t;

  function automatic int unsigned ts_width(input int unsigned data_width);
    return data_width - 1;
  endfunction

  function automatic int unsigned fifo_depth(input int unsigned depth_log2);
    return 32'd1 << depth_log2;
  endfunction

endpackage

// File: rtl/sync_event_fifo.sv
// -----------------------------------------------------------------------------
// sync_event_fifo
// Synchronous FIFO of 2^DEPTH_LOG2 entries with extra-wrap-bit pointers.
// Ports:
//   CLK        : clock, rising edge
//   RST        : synchronous active-high reset, empties the FIFO
//   push       : write push_data this cycle (ignored when full unless popping)
//   push_data  : entry to write
//   pop        : remove head this cycle (ignored when empty)
//   head       : current head entry (stale contents when empty)
//   full       : all entries occupied
//   empty      : no entries held
// -----------------------------------------------------------------------------
module sync_event_fifo
  import sync_event_pkg::*;
#(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned DEPTH_LOG2 = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int unsigned Depth = fifo_depth(DEPTH_LOG2);
  localparam int unsigned PtrW  = DEPTH_LOG2 + 1;

  logic [WIDTH-1:0] mem [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic             do_push, do_pop;

  // Equal index bits with differing wrap bits means the writer has lapped
  // the reader exactly once.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[DEPTH_LOG2] != rd_ptr_q[DEPTH_LOG2]) &&
                 (wr_ptr_q[DEPTH_LOG2-1:0] == rd_ptr_q[DEPTH_LOG2-1:0]);

  assign do_pop  = pop && !empty;
  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (do_push) mem[wr_ptr_q[DEPTH_LOG2-1:0]] <= push_data;
  end

  assign head = mem[rd_ptr_q[DEPTH_LOG2-1:0]];

endmodule

// File: rtl/sync_event_enq.sv
// -----------------------------------------------------------------------------
// sync_event_enq
// Debounces an already-synchronized level, timestamps every committed level
// change, queues the events and hands them downstream over an enq handshake.
// Ports:
//   CLK        : clock, rising edge
//   RST        : synchronous active-high reset
//   in         : synchronized input level
//   enq__ENA   : transfer strobe, = !fifo_empty && enq__RDY
//   enq_v      : event payload {level, timestamp}; 0 when the FIFO is empty
//   enq__RDY   : downstream can accept this cycle
//   level      : current debounced level
//   drop_count : saturating count of events lost to a full FIFO
//   fifo_empty : no events queued
// STABLE_CYCLES must be at least 1.
// -----------------------------------------------------------------------------
module sync_event_enq
  import sync_event_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned DEPTH_LOG2    = 2,
  parameter int unsigned DROP_WIDTH    = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  in,
  output logic                  enq__ENA,
  output logic [DATA_WIDTH-1:0] enq_v,
  input  logic                  enq__RDY,
  output logic                  level,
  output logic [DROP_WIDTH-1:0] drop_count,
  output logic                  fifo_empty
);

  localparam int unsigned TsWidth  = ts_width(DATA_WIDTH);
  localparam int unsigned CntWidth = $clog2(STABLE_CYCLES + 1);
  localparam logic [CntWidth-1:0] CntLast = CntWidth'(STABLE_CYCLES - 1);

  // ---------------------------------------------------------------------------
  // Free-running timestamp
  // ---------------------------------------------------------------------------
  logic [TsWidth-1:0] ts_q;

  always_ff @(posedge CLK) begin
    if (RST) ts_q <= '0;
    else     ts_q <= ts_q + TsWidth'(1);
  end

  // ---------------------------------------------------------------------------
  // Debounce FSM
  // cnt_q counts cycles the input has already disagreed with level_q; the
  // commit fires on the cycle that would make it STABLE_CYCLES.
  // ---------------------------------------------------------------------------
  dbnc_state_e         state_q, state_d;
  logic [CntWidth-1:0] cnt_q, cnt_d;
  logic                level_q, level_d;
  logic                commit;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    commit  = 1'b0;
    case (state_q)
      STABLE: begin
        if (in != level_q) begin
          if (STABLE_CYCLES == 1) begin
            commit = 1'b1;
          end else begin
            state_d = CHANGING;
            cnt_d   = CntWidth'(1);
          end
        end
      end
      CHANGING: begin
        if (in == level_q) begin
          // Glitch shorter than the debounce window: forget it.
          state_d = STABLE;
          cnt_d   = '0;
        end else if (cnt_q == CntLast) begin
          commit  = 1'b1;
          state_d = STABLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntWidth'(1);
        end
      end
      default: begin
        state_d = STABLE;
        cnt_d   = '0;
      end
    endcase
    if (commit) level_d = in;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= STABLE;
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

  assign level = level_q;

  // ---------------------------------------------------------------------------
  // Event queue and handshake
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] push_data;
  logic [DATA_WIDTH-1:0] fifo_head;
  logic                  fifo_full;
  logic                  fifo_empty_w;
  logic                  pop;

  // Event carries the new level and the timestamp of the commit cycle.
  assign push_data = {in, ts_q};

  assign pop = !fifo_empty_w && enq__RDY;

  sync_event_fifo #(
    .WIDTH      (DATA_WIDTH),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .CLK       (CLK),
    .RST       (RST),
    .push      (commit),
    .push_data (push_data),
    .pop       (pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty_w)
  );

  assign enq__ENA   = pop;
  assign enq_v      = fifo_empty_w ? '0 : fifo_head;
  assign fifo_empty = fifo_empty_w;

  // ---------------------------------------------------------------------------
  // Drop counter: a commit is lost only when full and nothing leaves this edge.
  // ---------------------------------------------------------------------------
  logic                  drop;
  logic [DROP_WIDTH-1:0] drop_cnt_q;

  assign drop = commit && fifo_full && !pop;

  always_ff @(posedge CLK) begin
    if (RST) begin
      drop_cnt_q <= '0;
    end else if (drop && (drop_cnt_q != '1)) begin
      drop_cnt_q <= drop_cnt_q + DROP_WIDTH'(1);
    end
  end

  assign drop_count = drop_cnt_q;

endmodule

// File: tb/tb_sync_event_enq.sv
// -----------------------------------------------------------------------------
// tb_sync_event_enq
// Directed scenarios plus randomized traffic for sync_event_enq, checked
// against a queue-based reference model. A second 8-bit instance covers
// timestamp wrap.
// -----------------------------------------------------------------------------
module tb_sync_event_enq;
  import sync_event_pkg::*;

  localparam int Stable = 4;
  localparam int Depth  = 4;

  logic        CLK = 1'b0;
  logic        RST, in_sig, enq_rdy;
  logic        enq_ena, level, fifo_empty;
  logic [31:0] enq_v;
  logic [7:0]  drop_count;

  logic        rst8, in8, rdy8;
  logic        ena8, level8, empty8;
  logic [7:0]  v8, drop8;

  always #5 CLK = ~CLK;

  sync_event_enq dut (
    .CLK        (CLK),
    .RST        (RST),
    .in         (in_sig),
    .enq__ENA   (enq_ena),
    .enq_v      (enq_v),
    .enq__RDY   (enq_rdy),
    .level      (level),
    .drop_count (drop_count),
    .fifo_empty (fifo_empty)
  );

  sync_event_enq #(
    .DATA_WIDTH    (8),
    .STABLE_CYCLES (4),
    .DEPTH_LOG2    (2),
    .DROP_WIDTH    (8)
  ) dut8 (
    .CLK        (CLK),
    .RST        (rst8),
    .in         (in8),
    .enq__ENA   (ena8),
    .enq_v      (v8),
    .enq__RDY   (rdy8),
    .level      (level8),
    .drop_count (drop8),
    .fifo_empty (empty8)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference model: run length of disagreement, event queue, drop tally.
  logic        m_level;
  int          m_run;
  logic [30:0] m_ts;
  logic [31:0] m_q[$];
  int          m_drop;

  // Observations captured in the most recent cycle.
  logic        cap_ena, cap_level, cap_empty;
  logic [31:0] cap_v;
  logic [7:0]  cap_drop;
  int          n_deliv;
  logic [31:0] obs_q[$];

  task automatic model_step();
    bit commit;
    bit pop;
    bit was_full;
    if (RST) begin
      m_level = 1'b0;
      m_run   = 0;
      m_ts    = '0;
      m_q.delete();
      m_drop  = 0;
    end else begin
      commit   = 1'b0;
      pop      = (m_q.size() != 0) && enq_rdy;
      was_full = (m_q.size() == Depth);
      m_run    = (in_sig != m_level) ? m_run + 1 : 0;
      if (m_run == Stable) begin
        commit = 1'b1;
        m_run  = 0;
      end
      if (pop) void'(m_q.pop_front());
      if (commit) begin
        if (was_full && !pop) begin
          if (m_drop < 255) m_drop++;
        end else begin
          m_q.push_back({in_sig, m_ts});
        end
        m_level = in_sig;
      end
      m_ts = m_ts + 31'd1;
    end
  endtask

  // Inputs already driven at the falling edge; sample 1 ns later, advance model.
  task automatic tick();
    logic        exp_ena;
    logic [31:0] exp_v;
    #1;
    exp_ena = (m_q.size() != 0) && enq_rdy;
    exp_v   = (m_q.size() != 0) ? m_q[0] : 32'h0;
    check_val("enq_ena", {31'b0, enq_ena}, {31'b0, exp_ena});
    check_val("enq_v", enq_v, exp_v);
    check_val("level", {31'b0, level}, {31'b0, m_level});
    check_val("fifo_empty", {31'b0, fifo_empty}, {31'b0, (m_q.size() == 0)});
    check_val("drop_count", {24'b0, drop_count}, m_drop);
    cap_ena   = enq_ena;
    cap_v     = enq_v;
    cap_level = level;
    cap_empty = fifo_empty;
    cap_drop  = drop_count;
    if (enq_ena) begin
      n_deliv++;
      obs_q.push_back(enq_v);
    end
    model_step();
    @(negedge CLK);
  endtask

  task automatic do_reset();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    n_deliv = 0;
    obs_q.delete();
  endtask

  initial begin
    logic        lv;
    event_t      ev;
    logic [7:0]  q8[$];
    int          c8[$];
    int          rdy_pct;
    RST = 1'b1; in_sig = 1'b0; enq_rdy = 1'b0;
    rst8 = 1'b1; in8 = 1'b0; rdy8 = 1'b1;
    m_level = 1'b0; m_run = 0; m_ts = '0; m_drop = 0;
    n_deliv = 0;
    @(negedge CLK);

    // Idle
    do_reset();
    enq_rdy = 1'b1;
    repeat (100) tick();
    check_val("idle_deliv", n_deliv, 0);
    check_val("idle_level", {31'b0, cap_level}, 0);
    check_val("idle_empty", {31'b0, cap_empty}, 1);

    // Rising edge: timestamp is 0 in cycle 0
    do_reset();
    for (int c = 0; c < 20; c++) begin
      in_sig = (c >= 10);
      tick();
      if (c == 13) check_val("rise_level13", {31'b0, cap_level}, 0);
      if (c == 14) begin
        check_val("rise_ena14", {31'b0, cap_ena}, 1);
        check_val("rise_v14", cap_v, 32'h8000000D);
        check_val("rise_level14", {31'b0, cap_level}, 1);
      end
    end
    check_val("rise_deliv", n_deliv, 1);

    // Glitch, then a real change must still need the full window
    do_reset();
    in_sig = 1'b1;
    repeat (3) tick();
    in_sig = 1'b0;
    repeat (10) tick();
    check_val("glitch_deliv", n_deliv, 0);
    check_val("glitch_level", {31'b0, cap_level}, 0);
    check_val("glitch_empty", {31'b0, cap_empty}, 1);
    in_sig = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (i == 3) check_val("post_glitch_l3", {31'b0, cap_level}, 0);
      if (i == 4) check_val("post_glitch_l4", {31'b0, cap_level}, 1);
    end

    // Backpressure: 6 commits into a 4-deep FIFO
    do_reset();
    enq_rdy = 1'b0;
    lv = 1'b0;
    for (int k = 0; k < 6; k++) begin
      lv = ~lv;
      in_sig = lv;
      repeat (6) tick();
    end
    check_val("bp_drop", {24'b0, cap_drop}, 2);
    check_val("bp_not_empty", {31'b0, cap_empty}, 0);
    enq_rdy = 1'b1;
    repeat (6) tick();
    check_val("bp_deliv", obs_q.size(), 4);
    if (obs_q.size() == 4) begin
      check_val("bp_ev0", obs_q[0], 32'h80000003);
      check_val("bp_ev1", obs_q[1], 32'h00000009);
      check_val("bp_ev2", obs_q[2], 32'h8000000F);
      check_val("bp_ev3", obs_q[3], 32'h00000015);
      ev = obs_q[2];
      check_val("bp_ev2_level", {31'b0, ev.level}, 1);
    end
    check_val("bp_empty_after", {31'b0, cap_empty}, 1);

    // Full FIFO, ready rises in the same cycle as a commit
    do_reset();
    enq_rdy = 1'b0;
    lv = 1'b0;
    for (int k = 0; k < 4; k++) begin
      lv = ~lv;
      in_sig = lv;
      repeat (6) tick();
    end
    in_sig = 1'b1;
    for (int j = 0; j < 10; j++) begin
      enq_rdy = (j >= 3);
      tick();
    end
    check_val("fp_drop", {24'b0, cap_drop}, 0);
    check_val("fp_deliv", obs_q.size(), 5);
    if (obs_q.size() == 5) check_val("fp_last", obs_q[4], 32'h8000001B);
    check_val("fp_empty", {31'b0, cap_empty}, 1);

    // Reset with events queued and a debounce in flight
    do_reset();
    enq_rdy = 1'b0;
    in_sig = 1'b1; repeat (6) tick();
    in_sig = 1'b0; repeat (6) tick();
    in_sig = 1'b1; repeat (2) tick();
    check_val("mid_queued", {31'b0, cap_empty}, 0);
    enq_rdy = 1'b1;
    in_sig = 1'b0;
    RST = 1'b1;
    tick();
    RST = 1'b0;
    tick();
    check_val("mid_ena", {31'b0, cap_ena}, 0);
    check_val("mid_drop", {24'b0, cap_drop}, 0);
    check_val("mid_level", {31'b0, cap_level}, 0);
    check_val("mid_empty", {31'b0, cap_empty}, 1);

    // Timestamp wrap on the 8-bit instance
    in_sig = 1'b0;
    rst8 = 1'b1;
    tick();
    rst8 = 1'b0;
    for (int c = 0; c < 266; c++) begin
      in8 = (c >= 124) && (c < 254);
      #1;
      if (ena8) begin
        q8.push_back(v8);
        c8.push_back(c);
      end
      tick();
    end
    check_val("wrap_count", q8.size(), 2);
    if (q8.size() == 2) begin
      check_val("wrap_v0", {24'b0, q8[0]}, 32'hFF);
      check_val("wrap_c0", c8[0], 128);
      check_val("wrap_v1", {24'b0, q8[1]}, 32'h01);
      check_val("wrap_c1", c8[1], 258);
    end
    check_val("wrap_level", {31'b0, level8}, 0);
    check_val("wrap_empty", {31'b0, empty8}, 1);
    check_val("wrap_drop", {24'b0, drop8}, 0);

    // Randomized traffic with occasional resets
    do_reset();
    rdy_pct = 50;
    for (int i = 0; i < 3000; i++) begin
      if ((i % 200) == 0) begin
        case ($urandom_range(0, 2))
          0:       rdy_pct = 10;
          1:       rdy_pct = 50;
          default: rdy_pct = 95;
        endcase
      end
      if ($urandom_range(0, 7) == 0) in_sig = ~in_sig;
      enq_rdy = ($urandom_range(0, 99) < rdy_pct);
      RST = ($urandom_range(0, 599) == 0);
      tick();
    end
    RST = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
